adq_temperatura: RTL

Acquisition front-end that produces temperature samples for the monitoring core. It acts as a serial (SPI mode 0, read-only) master to an external digital temperature sensor. It periodically clocks out a 16-bit frame, extracts the signed 11-bit reading (units of 0.1 °C), checks the sensor fault bit, and presents the sample with a one-cycle valid strobe. Its temp_salida/temp_valida output is the source that drives the monitor's temperature input.

---
 rtl/adq_temperatura.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/adq_temperatura.sv
// adq_temperatura: SPI mode-0 read-only master for a digital temperature sensor.
// Samples a 16-bit frame every SAMPLE_PERIOD clocks and extracts the signed 11-bit reading (0.1 C/LSB) and the fault bit.
// Optional macro PROMEDIO_EN: when defined, temp_salida is a 4-sample moving average of good frames.
module adq_temperatura #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        habilitar,
  input  logic        miso,
  output logic        sclk,
  output logic        cs_n,
  output logic [10:0] temp_salida,
  output logic        temp_valida,
  output logic        sensor_falla,
  output logic        ocupado
);

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [TW-1:0] T_FIN = TW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] C_MED = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_FIN = CW'(2 * CLK_DIV - 1);

  if (CLK_DIV < 2) begin : g_chk_div
    $error("adq_temperatura: CLK_DIV must be >= 2");
  end
  if (SAMPLE_PERIOD <= 2 * CLK_DIV * 17 + 2) begin : g_chk_periodo
    $error("adq_temperatura: SAMPLE_PERIOD too short for one frame");
  end

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    UPDATE
  } estado_t;

  estado_t        estado;
  logic [TW-1:0]  timer;
  logic [CW-1:0]  cnt;
  logic [3:0]     nbit;
  logic [10:0]    dato;        // frame bits [15:5], the signed reading
  logic           falla_bit;   // frame bit 0
  logic [10:0]    valor_nuevo; // value loaded into temp_salida on a good frame
  logic           arranque;

  // A conversion starts only from IDLE, at terminal count, while enabled.
  assign arranque = (estado == IDLE) && (timer == T_FIN) && habilitar;

  // Sample-period timer: free-runs up to terminal count, holds there until a conversion starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (arranque) begin
      timer <= '0;
    end else if (timer != T_FIN) begin
      timer <= timer + TW'(1);
    end
  end

  // Frame sequencer: chip select, serial clock, bit capture and the registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado       <= IDLE;
      cnt          <= '0;
      nbit         <= '0;
      dato         <= '0;
      falla_bit    <= 1'b0;
      sclk         <= 1'b0;
      cs_n         <= 1'b1;
      temp_salida  <= '0;
      temp_valida  <= 1'b0;
      sensor_falla <= 1'b0;
      ocupado      <= 1'b0;
    end else begin
      temp_valida <= 1'b0;
      case (estado)
        IDLE: begin
          if (arranque) begin
            estado  <= CS_SETUP;
            cs_n    <= 1'b0;
            ocupado <= 1'b1;
            cnt     <= '0;
          end
        end
        CS_SETUP: begin
          if (cnt == C_MED) begin
            estado <= SHIFT;
            cnt    <= '0;
            nbit   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SHIFT: begin
          if (cnt == C_MED) begin
            // sclk rises on this edge; miso has been stable since the previous falling edge.
            sclk <= 1'b1;
            if (nbit <= 4'd10) dato <= {dato[9:0], miso};
            if (nbit == 4'd15) falla_bit <= miso;
            cnt <= cnt + CW'(1);
          end else if (cnt == C_FIN) begin
            sclk <= 1'b0;
            cnt  <= '0;
            if (nbit == 4'd15) begin
              estado <= CS_HOLD;
            end else begin
              nbit <= nbit + 4'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CS_HOLD: begin
          if (cnt == C_MED) begin
            estado <= UPDATE;
            cs_n   <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        UPDATE: begin
          estado  <= IDLE;
          ocupado <= 1'b0;
          if (falla_bit) begin
            sensor_falla <= 1'b1;
          end else begin
            temp_salida  <= valor_nuevo;
            temp_valida  <= 1'b1;
            sensor_falla <= 1'b0;
          end
        end
        default: begin
          estado <= IDLE;
          cs_n   <= 1'b1;
          sclk   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PROMEDIO_EN
  // The window holds the three previous good samples; the incoming sample is the fourth entry.
  logic signed [10:0] hist [3];
  logic               cebado;
  logic signed [12:0] suma;

  // Window sum sign-extended to 13 bits; the top 11 bits are the floor of sum/4.
  always_comb begin
    suma = $signed({{2{dato[10]}}, dato})
         + $signed({{2{hist[0][10]}}, hist[0]})
         + $signed({{2{hist[1][10]}}, hist[1]})
         + $signed({{2{hist[2][10]}}, hist[2]});
  end

  assign valor_nuevo = cebado ? suma[12:2] : dato;

  // Window update on good frames only; the first good frame after reset fills every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cebado <= 1'b0;
      for (int i = 0; i < 3; i++) hist[i] <= '0;
    end else if (estado == UPDATE && !falla_bit) begin
      cebado <= 1'b1;
      if (!cebado) begin
        for (int i = 0; i < 3; i++) hist[i] <= dato;
      end else begin
        hist[0] <= dato;
        hist[1] <= hist[0];
        hist[2] <= hist[1];
      end
    end
  end
`else
  assign valor_nuevo = dato;
`endif

endmodule
